// File: rtl/mul_req_arbiter.sv
// mul_req_arbiter
//   Shares one external pipelined 32x32 multiplier among NUM_REQ requesters.
//   Requests are issued round-robin, at most one per cycle. A tracking pipe
//   of MUL_LAT {valid, id} stages follows each operation through the fixed
//   multiplier latency, and the product is pushed into the owner's response
//   FIFO. A per-requester credit counter (ops in flight + FIFO entries)
//   blocks issue once RSP_DEPTH operations are outstanding, so a FIFO can
//   never overflow even if its requester stops popping.
//
// Handshakes:
//   req_valid/req_ready: an op transfers in a cycle where both are 1 at the
//   rising edge. req_ready is combinational from req_valid; a requester must
//   never make req_valid depend on req_ready. rsp_valid/rsp_ready: the FIFO
//   head transfers in a cycle where both are 1 at the rising edge.
//
// Ports:
//   mul_clk     clock
//   resetn      synchronous reset, active HIGH (1 = reset)
//   req_valid   per-requester request valid
//   req_ready   per-requester grant (accepted this cycle)
//   req_signed  per-requester sign mode (1 = signed)
//   req_x/req_y packed operands, requester i at [32i+31:32i]
//   rsp_valid   per-requester response FIFO non-empty
//   rsp_ready   per-requester pop of the FIFO head
//   rsp_result  packed FIFO head products, requester i at [64i+63:64i]
//   mul_x/mul_y/mul_signed  operands to the multiplier (0 when idle)
//   mul_result  product from the multiplier, MUL_LAT cycles after issue
//   busy        any op in flight or any response FIFO non-empty

module mul_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MUL_LAT   = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic                   mul_clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_signed,
  input  logic [32*NUM_REQ-1:0]  req_x,
  input  logic [32*NUM_REQ-1:0]  req_y,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [64*NUM_REQ-1:0]  rsp_result,
  output logic [31:0]            mul_x,
  output logic [31:0]            mul_y,
  output logic                   mul_signed,
  input  logic [63:0]            mul_result,
  output logic                   busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Round-robin pointer: index of the most recently granted requester.
  logic [IDW-1:0] ptr_q, ptr_d;

  // Credits: ops in flight plus entries held in the FIFO, per requester.
  logic [CW-1:0]  cnt_q [NUM_REQ];
  logic [CW-1:0]  cnt_d [NUM_REQ];

  // Tracking pipe.
  logic [MUL_LAT-1:0] trk_vld_q, trk_vld_d;
  logic [IDW-1:0]     trk_id_q [MUL_LAT];
  logic [IDW-1:0]     trk_id_d [MUL_LAT];

  // Response FIFOs.
  logic [63:0]    mem_q [NUM_REQ][RSP_DEPTH];
  logic [63:0]    mem_d [NUM_REQ][RSP_DEPTH];
  logic [PW-1:0]  wr_q  [NUM_REQ];
  logic [PW-1:0]  wr_d  [NUM_REQ];
  logic [PW-1:0]  rd_q  [NUM_REQ];
  logic [PW-1:0]  rd_d  [NUM_REQ];
  logic [CW-1:0]  occ_q [NUM_REQ];
  logic [CW-1:0]  occ_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               issue;
  logic [IDW-1:0]     grant_idx;

  // ---------------------------------------------------------------------
  // Arbitration. Eligibility uses only registered credits, so a pop in the
  // same cycle cannot reopen a full requester until the next cycle. Grants
  // are suppressed while reset is asserted.
  // ---------------------------------------------------------------------
  always_comb begin
    elig      = '0;
    grant     = '0;
    grant_idx = '0;
    issue     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = !resetn && req_valid[i] && (cnt_q[i] < CW'(RSP_DEPTH));
    end
    // Search starts one past the last winner and wraps.
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!issue && elig[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        issue       = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Operand mux to the multiplier; zeros when nothing issues.
  always_comb begin
    mul_x      = '0;
    mul_y      = '0;
    mul_signed = 1'b0;
    if (issue) begin
      mul_x      = req_x[32*int'(grant_idx) +: 32];
      mul_y      = req_y[32*int'(grant_idx) +: 32];
      mul_signed = req_signed[grant_idx];
    end
  end

  // ---------------------------------------------------------------------
  // FIFO outputs and busy.
  // ---------------------------------------------------------------------
  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i]            = (occ_q[i] != '0);
      rsp_result[64*i +: 64]  = mem_q[i][rd_q[i]];
    end
  end

  assign busy = (|trk_vld_q) || (|rsp_valid);

  // ---------------------------------------------------------------------
  // Next state: pointer, tracking pipe, credits, FIFOs.
  // ---------------------------------------------------------------------
  always_comb begin
    ptr_d = issue ? grant_idx : ptr_q;

    trk_vld_d    = '0;
    trk_vld_d[0] = issue;
    trk_id_d[0]  = grant_idx;
    for (int s = 1; s < MUL_LAT; s++) begin
      trk_vld_d[s] = trk_vld_q[s-1];
      trk_id_d[s]  = trk_id_q[s-1];
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // The last tracking stage lines up with the product on mul_result.
      push[i] = trk_vld_q[MUL_LAT-1] && (trk_id_q[MUL_LAT-1] == IDW'(i));
      pop[i]  = rsp_valid[i] && rsp_ready[i];

      cnt_d[i] = cnt_q[i];
      if (grant[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!grant[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end

      mem_d[i] = mem_q[i];
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      occ_d[i] = occ_q[i];
      if (push[i]) begin
        mem_d[i][wr_q[i]] = mul_result;
        wr_d[i] = (wr_q[i] == PW'(RSP_DEPTH - 1)) ? '0 : wr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_d[i] = (rd_q[i] == PW'(RSP_DEPTH - 1)) ? '0 : rd_q[i] + PW'(1);
      end
      if (push[i] && !pop[i]) begin
        occ_d[i] = occ_q[i] + CW'(1);
      end else if (!push[i] && pop[i]) begin
        occ_d[i] = occ_q[i] - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers. Clearing the tracking valids on reset discards whatever the
  // multiplier still has in its pipe.
  // ---------------------------------------------------------------------
  always_ff @(posedge mul_clk) begin
    if (resetn) begin
      ptr_q     <= IDW'(NUM_REQ - 1);
      trk_vld_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        trk_id_q[s] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        occ_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      trk_vld_q <= trk_vld_d;
      for (int s = 0; s < MUL_LAT; s++) begin
        trk_id_q[s] <= trk_id_d[s];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        occ_q[i] <= occ_d[i];
      end
    end
  end

  // FIFO storage is pure data; only the pointers and occupancy need reset.
  always_ff @(posedge mul_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Credits make a push into a full FIFO impossible.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ovf
    a_no_overflow: assert property (@(posedge mul_clk) disable iff (resetn)
      !(push[g] && (occ_q[g] == CW'(RSP_DEPTH))));
  end

endmodule

// File: doc/mul_req_arbiter.md
Name: mul_req_arbiter

Overview:
- Shares one pipelined 32x32 Booth/Wallace multiplier among NUM_REQ requesters, e.g. integer pipe and MAC unit.
- Round-robin issue, at most one operation per cycle.
- Tracks each operation's owner through the fixed multiplier latency.
- Returns each 64-bit product to its owner through a per-requester response FIFO.
- Credit check guarantees no product is ever dropped when a requester backpressures.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
MUL_LAT, 3, cycles from issue edge to product valid on mul_result
RSP_DEPTH, 4, entries per response FIFO; also max outstanding ops per requester

Ports:
mul_clk  in  1  clock
resetn  in  1  synchronous, active-high reset (despite the name, 1 = reset)
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted this cycle
req_signed  in  NUM_REQ  1 = signed multiply, 0 = unsigned
req_x  in  32*NUM_REQ  multiplicand, requester i at [32i+31:32i]
req_y  in  32*NUM_REQ  multiplier operand, same packing
rsp_valid  out  NUM_REQ  response FIFO non-empty
rsp_ready  in  NUM_REQ  requester consumes head entry
rsp_result  out  64*NUM_REQ  FIFO head product, requester i at [64i+63:64i]
mul_x  out  32  operand to multiplier
mul_y  out  32  operand to multiplier
mul_signed  out  1  sign mode to multiplier
mul_result  in  64  product from multiplier, MUL_LAT cycles after issue
busy  out  1  any op in flight or any FIFO non-empty

Behaviour:
- Reset (resetn=1 at clock edge):
  - All FIFOs empty; all outstanding counters 0; tracking pipe valid bits 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - Outputs: rsp_valid=0, req_ready=0, busy=0, mul_x=mul_y=0, mul_signed=0.
- Eligibility: elig[i] = req_valid[i] && cnt[i] < RSP_DEPTH.
  - cnt[i] is a registered count of ops in flight plus entries held in FIFO i.
- Grant: one-hot. Priority search starts at pointer+1 and wraps modulo NUM_REQ.
  - req_ready[i] = grant[i], combinational from req_valid; legal because requesters must not make valid depend on ready.
  - Pointer updates to the granted index only on issue; it holds otherwise.
- Issue (any grant):
  - mul_x/mul_y/mul_signed = granted requester's operands, combinational.
  - With no grant, all three are driven to 0.
- Tracking pipe: MUL_LAT stages of {valid, id}.
  - Stage 0 is loaded with {issue, grant index} at the issue edge.
  - When stage MUL_LAT-1 is valid, mul_result is pushed into FIFO[id] at that cycle's edge.
- Latency: an op accepted at edge T gives rsp_valid at cycle T+MUL_LAT+1 if the FIFO was empty.
- Throughput: one op per cycle aggregate. Operations are never reordered within a requester.
- Counter update:
  - cnt[i] +1 on issue to i.
  - cnt[i] -1 on rsp_valid[i] && rsp_ready[i].
  - Both in the same cycle: unchanged.
- Credits: no combinational bypass. At cnt=RSP_DEPTH with a pop in the same cycle, req_ready stays 0; it may assert the next cycle.
- FIFO: circular buffer, wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Overflow is impossible by credit. An assertion fires if a push occurs when full.
  - rsp_result is don't-care while rsp_valid=0; the RTL drives the head entry.
- busy = any tracking valid || any FIFO non-empty.
- Reset mid-operation: all in-flight ops are discarded.
  - Products emerging after reset are ignored because tracking valids are cleared.
  - The multiplier shares resetn.

Test Plan:
1. MUL_LAT=3: req0 signed, x=0xFFFFFFFD (-3), y=7, accepted at edge T -> rsp0_valid at cycle T+4, rsp_result0=0xFFFFFFFFFFFFFFEB; busy low the cycle after the pop.
2. req1 unsigned, x=y=0xFFFFFFFF -> rsp_result1=0xFFFFFFFE00000001; signed flag correctly routed per requester.
3. Both req_valid held high, rsp_ready=all 1s, 8 ops each -> grants alternate 0,1,0,1...; 16 issues in 16 consecutive cycles; each requester receives its 8 results in order.
4. rsp0_ready=0, req0 and req1 valid continuously -> exactly 4 req0 ops accepted, then req_ready0=0 while req1 issues every cycle. Raise rsp0_ready -> after one pop, req0 issues again one cycle later.
5. cnt0=4 with pop and req0_valid in the same cycle -> req_ready0=0 that cycle, 1 the next.
6. Assert resetn with 2 ops in flight and 1 FIFO entry -> all rsp_valid stay 0 thereafter, busy=0, and the next simultaneous request is granted to requester 0.
